// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl -- boot/load controller and address-port arbiter for the
// instruction RAM of the single-cycle MIPS core.
//
// In RUN the RAM address follows the CPU fetch PC. A load_start request holds
// the CPU, gathers loader bytes into big-endian words and writes them to
// sequential RAM addresses, then pulses load_done and releases the CPU.
//
// Optional feature macro: IMEM_BOOT_CSUM_EN -- after the data words a 32-bit
// checksum word (XOR of all data words) is received and verified; on mismatch
// load_err is set and the CPU stays held.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cpu_pc            CPU byte-address fetch PC
//   load_start        one-cycle load request, load_len sampled with it
//   load_len          number of words to load (0..DEPTH valid)
//   byte_valid/data   loader byte stream; byte_ready = block accepts
//   mem_addr          RAM word address (PC in RUN, word counter otherwise)
//   mem_we/mem_wdata  RAM write strobe (one cycle per word) and data
//   cpu_hold          CPU stall
//   load_done         one-cycle pulse on successful completion
//   load_err          sticky error, cleared by next accepted load_start
module imem_boot_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_pc,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

`ifdef IMEM_BOOT_CSUM_EN
  typedef enum logic [1:0] {RUN, LOAD, CHECK, RELEASE} state_t;
`else
  typedef enum logic [1:0] {RUN, LOAD, RELEASE} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [23:0]     shreg;     // first three bytes of the word in flight
  logic            hold_q;
  logic            accept;
  logic            word_done; // 4th byte of a word accepted this cycle
  logic            last_word;
  logic            start_ok;
  logic            unused_pc;
`ifdef IMEM_BOOT_CSUM_EN
  logic [31:0]     csum_q;
  logic            csum_ok;
`endif

  assign unused_pc = ^{cpu_pc[31:ADDR_W+2], cpu_pc[1:0]};

  assign accept    = byte_valid & byte_ready;
  assign word_done = accept & (byte_cnt == 2'd3);
  assign last_word = (word_cnt == len_q - ONE_L);
  assign start_ok  = (state_q == RUN) & load_start & (load_len <= DEPTH_L);

  assign mem_addr  = (state_q == RUN) ? cpu_pc[ADDR_W+1:2] : word_cnt[ADDR_W-1:0];
  assign load_done = (state_q == RELEASE);
  assign cpu_hold  = hold_q;

`ifdef IMEM_BOOT_CSUM_EN
  // Checksum bytes may start arriving during the final write cycle; the byte
  // assembler is state-independent so they land in shreg as usual.
  assign byte_ready = (state_q == LOAD) | (state_q == CHECK);
  assign csum_ok    = ({shreg, byte_data} == csum_q);
`else
  // Nothing follows the last word, so refuse bytes during its write cycle.
  assign byte_ready = (state_q == LOAD) & ~(mem_we & last_word);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (load_start) begin
          if (load_len == '0)           state_d = RELEASE;
          else if (load_len <= DEPTH_L) state_d = LOAD;
        end
      end
      LOAD: begin
        if (mem_we & last_word) begin
`ifdef IMEM_BOOT_CSUM_EN
          state_d = CHECK;
`else
          state_d = RELEASE;
`endif
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      CHECK: begin
        if (word_done) state_d = csum_ok ? RELEASE : RUN;
      end
`endif
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      len_q     <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      hold_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      load_err  <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      mem_we  <= (state_q == LOAD) & word_done;

      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= {shreg[15:0], byte_data};
      end

      if ((state_q == LOAD) & word_done) begin
        mem_wdata <= {shreg, byte_data};
`ifdef IMEM_BOOT_CSUM_EN
        csum_q    <= csum_q ^ {shreg, byte_data};
`endif
      end

      // word_cnt advances at the end of each write cycle
      if ((state_q == LOAD) & mem_we) word_cnt <= word_cnt + ONE_L;

      if (start_ok) begin
        len_q    <= load_len;
        word_cnt <= '0;
        byte_cnt <= '0;
        load_err <= 1'b0;
        hold_q   <= 1'b1;
`ifdef IMEM_BOOT_CSUM_EN
        csum_q   <= '0;
`endif
      end else if ((state_q == RUN) & load_start) begin
        load_err <= 1'b1;
      end

      if (state_q == RELEASE) hold_q <= 1'b0;

`ifdef IMEM_BOOT_CSUM_EN
      // Mismatch: flag error, return to RUN, keep the CPU held.
      if ((state_q == CHECK) & word_done & ~csum_ok) load_err <= 1'b1;
`endif
    end
  end

endmodule
